// File: rtl/riscv_test_monitor.sv
// riscv_test_monitor
//   Sticky pass/fail verdict monitor for riscv-tests runs. Sits beside the
//   core, watches the program counter and x3 (gp), and latches one verdict:
//   pass, fail (with the failing TESTNUM), timeout, or optional PC stall.
//
//   Optional feature macro: RISCV_TEST_MONITOR_STALL_DETECT_EN
//     defined   -> prev_pc register + stall counter, stall can end the run
//     undefined -> no stall hardware, stall tied to 0
//
// Parameters
//   HALT_PC     PC value at which the program has reached its verdict point
//   TIMEOUT     max RUN cycles before timeout (>= 2)
//   STALL_LIMIT consecutive unchanged-PC cycles that declare a stall
//
// Ports
//   clk        core clock, rising edge
//   rst        synchronous active-high reset
//   enable     start monitoring (IDLE -> RUN)
//   pc         current core PC
//   gp         current value of x3
//   done       any verdict latched
//   pass       gp == 1 at HALT_PC
//   fail       gp != 1 at HALT_PC
//   timeout    TIMEOUT reached or stall detected
//   stall      PC stall detected (subset of timeout)
//   fail_test  gp[31:1] captured at the fail verdict, else 0
//   cycles     RUN cycles elapsed, frozen at the verdict
module riscv_test_monitor #(
  parameter logic [31:0] HALT_PC     = 32'h44,
  parameter int unsigned TIMEOUT     = 5000,
  parameter int unsigned STALL_LIMIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        stall,
  output logic [30:0] fail_test,
  output logic [31:0] cycles
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PASS,
    FAIL,
    TMO
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [30:0] fail_test_q, fail_test_d;
  logic        stall_q, stall_d;
  logic        stall_hit;

`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
  localparam logic [31:0] STALL_LIMIT_W = 32'(STALL_LIMIT);

  logic [31:0] prev_pc_q;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // The counter runs only while a repeated, non-halt PC is observed; any
  // other PC restarts the count from zero.
  always_comb begin
    stall_cnt_d = '0;
    if ((pc == prev_pc_q) && (pc != HALT_PC))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign stall_hit = (stall_cnt_d == STALL_LIMIT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else if (state_q == RUN) begin
      prev_pc_q   <= pc;
      stall_cnt_q <= stall_cnt_d;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cycles_d    = cycles_q;
    fail_test_d = fail_test_q;
    stall_d     = stall_q;
    case (state_q)
      IDLE: begin
        if (enable)
          state_d = RUN;
      end
      RUN: begin
        cycles_d = cycles_q + 32'd1;
        // Halt is checked first so it wins over a coincident timeout/stall.
        if (pc == HALT_PC) begin
          if (gp == 32'd1) begin
            state_d = PASS;
          end else begin
            state_d     = FAIL;
            fail_test_d = gp[31:1];
          end
        end else if (cycles_d == TIMEOUT_W) begin
          state_d = TMO;
        end else if (stall_hit) begin
          state_d = TMO;
          stall_d = 1'b1;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cycles_q    <= '0;
      fail_test_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycles_q    <= cycles_d;
      fail_test_q <= fail_test_d;
      stall_q     <= stall_d;
    end
  end

  assign pass      = (state_q == PASS);
  assign fail      = (state_q == FAIL);
  assign timeout   = (state_q == TMO);
  assign done      = pass | fail | timeout;
  assign stall     = stall_q;
  assign fail_test = fail_test_q;
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_riscv_test_monitor.sv
module tb_riscv_test_monitor;

  localparam logic [31:0] HALT     = 32'h44;
  localparam int          TMO_LIM  = 100;
  localparam int          STALL_LIM = 16;

  logic        clk = 1'b0;
  logic        rst, enable;
  logic [31:0] pc, gp;
  logic        done, pass, fail, timeout, stall;
  logic [30:0] fail_test;
  logic [31:0] cycles;

  riscv_test_monitor #(
    .HALT_PC    (HALT),
    .TIMEOUT    (TMO_LIM),
    .STALL_LIMIT(STALL_LIM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pc       (pc),
    .gp       (gp),
    .done     (done),
    .pass     (pass),
    .fail     (fail),
    .timeout  (timeout),
    .stall    (stall),
    .fail_test(fail_test),
    .cycles   (cycles)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: verdict kind + run length, derived from the rules.
  // verdict: 0 none, 1 pass, 2 fail, 3 timeout, 4 stall
  bit          m_running;
  int          m_verdict;
  longint      m_cyc;
  logic [30:0] m_testnum;
  logic [31:0] m_last_pc;
  int          m_repeats;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0;
    m_verdict = 0;
    m_cyc     = 0;
    m_testnum = '0;
    m_last_pc = '0;
    m_repeats = 0;
  endtask

  task automatic model_edge(input logic r, input logic en, input logic [31:0] p, input logic [31:0] g);
    bit rep;
    if (r) begin
      model_reset();
    end else if (m_verdict != 0) begin
      // verdict is sticky
    end else if (!m_running) begin
      if (en) m_running = 1;
    end else begin
      m_cyc++;
      rep = (p == m_last_pc) && (p != HALT);
      m_repeats = rep ? m_repeats + 1 : 0;
      m_last_pc = p;
      if (p == HALT) begin
        m_verdict = (g == 32'd1) ? 1 : 2;
        if (g != 32'd1) m_testnum = g >> 1;
      end else if (m_cyc == TMO_LIM) begin
        m_verdict = 3;
      end
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
      else if (m_repeats == STALL_LIM) begin
        m_verdict = 4;
      end
`endif
      if (m_verdict != 0) m_running = 0;
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".done"},      {31'd0, done},      {31'd0, 1'(m_verdict != 0)});
    chk({ctx, ".pass"},      {31'd0, pass},      {31'd0, 1'(m_verdict == 1)});
    chk({ctx, ".fail"},      {31'd0, fail},      {31'd0, 1'(m_verdict == 2)});
    chk({ctx, ".timeout"},   {31'd0, timeout},   {31'd0, 1'(m_verdict >= 3)});
    chk({ctx, ".stall"},     {31'd0, stall},     {31'd0, 1'(m_verdict == 4)});
    chk({ctx, ".fail_test"}, {1'b0, fail_test},  {1'b0, m_testnum});
    chk({ctx, ".cycles"},    cycles,             32'(m_cyc));
  endtask

  task automatic step(input string ctx, input logic r, input logic en,
                      input logic [31:0] p, input logic [31:0] g);
    rst = r; enable = en; pc = p; gp = g;
    @(posedge clk);
    #1;
    model_edge(r, en, p, g);
    check_all(ctx);
  endtask

  task automatic do_reset();
    step("reset", 1'b1, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1; enable = 1'b0; pc = '0; gp = '0;
    model_reset();

    // Reset state
    do_reset();
    do_reset();
    chk("reset_cycles_const", cycles, 32'd0);

    // Idle while enable low
    for (int i = 0; i < 20; i++) step("idle", 1'b0, 1'b0, $urandom, $urandom);
    chk("idle_cycles_const", cycles, 32'd0);

    // Pass at cycle 17
    step("pass_en", 1'b0, 1'b1, 32'h0, $urandom);
    for (int k = 1; k <= 17; k++)
      step("pass_run", 1'b0, 1'($urandom), 32'(4 * k), (k == 17) ? 32'd1 : $urandom);
    chk("pass_flag_const", {31'd0, pass}, 32'd1);
    chk("pass_cycles_const", cycles, 32'd17);
    for (int i = 0; i < 100; i++)
      step("pass_hold", 1'b0, 1'($urandom), $urandom_range(0, 1) ? HALT : $urandom, $urandom);

    // Fail with TESTNUM 3
    do_reset();
    step("fail_en", 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 1; k <= 5; k++) step("fail_run", 1'b0, 1'b1, 32'(8 * k), $urandom);
    step("fail_halt", 1'b0, 1'b1, HALT, 32'h7);
    chk("fail_test_const", {1'b0, fail_test}, 32'd3);
    chk("fail_pass_const", {31'd0, pass}, 32'd0);
    for (int i = 0; i < 10; i++) step("fail_hold", 1'b0, 1'b1, HALT, 32'd1);

    // Timeout; enable dropped mid-run has no effect
    do_reset();
    step("tmo_en", 1'b0, 1'b1, 32'h0, 32'h0);
    n = 0;
    while (m_verdict == 0 && n < 200) begin
      step("tmo_run", 1'b0, 1'(n < 30), 32'h1000 + 32'(4 * n), $urandom);
      n++;
    end
    chk("tmo_flag_const", {31'd0, timeout}, 32'd1);
    chk("tmo_cycles_const", cycles, 32'd100);
    chk("tmo_stall_const", {31'd0, stall}, 32'd0);

    // Halt on the final cycle beats timeout
    do_reset();
    step("sim_en", 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 1; k < TMO_LIM; k++) step("sim_run", 1'b0, 1'b1, 32'h2000 + 32'(4 * k), 32'd1);
    step("sim_halt", 1'b0, 1'b1, HALT, 32'd1);
    chk("sim_pass_const", {31'd0, pass}, 32'd1);
    chk("sim_tmo_const", {31'd0, timeout}, 32'd0);

    // Reset mid-run at cycles = 50
    do_reset();
    step("mid_en", 1'b0, 1'b1, 32'h0, 32'h0);
    for (int k = 1; k <= 50; k++) step("mid_run", 1'b0, 1'b1, 32'h3000 + 32'(4 * k), $urandom);
    chk("mid_cycles50_const", cycles, 32'd50);
    step("mid_rst", 1'b1, 1'b1, 32'h3000, $urandom);
    chk("mid_cycles0_const", cycles, 32'd0);
    for (int i = 0; i < 5; i++) step("mid_idle", 1'b0, 1'b0, HALT, 32'd1);

    // PC held at 0x100
    do_reset();
    step("stall_en", 1'b0, 1'b1, 32'h0, 32'h0);
    n = 0;
    while (m_verdict == 0 && n < 200) begin
      step("stall_run", 1'b0, 1'b1, 32'h100, $urandom);
      n++;
    end
`ifdef RISCV_TEST_MONITOR_STALL_DETECT_EN
    chk("stall_flag_const", {31'd0, stall}, 32'd1);
    chk("stall_cycles_const", cycles, 32'd17);
`else
    chk("stall_flag_const", {31'd0, stall}, 32'd0);
    chk("stall_cycles_const", cycles, 32'd100);
`endif
    chk("stall_tmo_const", {31'd0, timeout}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
